lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYC, default 40: clk cycles busy is held after any accepted command or data write.
REQ-002 SHALL have parameter DDRAM_WORDS, default 80: number of display-data bytes stored.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 lcd_en  input  1  enable strobe from the CPU LCD port.
REQ-006 lcd_rs  input  1  0 = instruction, 1 = data.
REQ-007 lcd_rw  input  1  0 = write, 1 = read.
REQ-008 lcd_data_in  input  8  bus value driven by the CPU.
REQ-009 lcd_data_out  output  8  read-back value.
REQ-010 lcd_data_oe  output  1  high while lcd_data_out is valid for the CPU.
REQ-011 busy  output  1  busy flag.
REQ-012 disp_on  output  1  display-on bit (D) from display control.
REQ-013 overrun  output  1  sticky flag: a write arrived while busy.
REQ-014 dbg_addr  input  7  debug DDRAM address.
REQ-015 dbg_data  output  8  combinational DDRAM[dbg_addr] (0x00 when out of range).

Function
REQ-016 SHALL register lcd_en into en_q each cycle; a strobe is the cycle with en_q=1 and lcd_en=0; lcd_rs/lcd_rw/lcd_data_in SHALL be sampled on that same cycle.
REQ-017 Valid DDRAM addresses: 0x00-0x27 (line 1) and 0x40-0x67 (line 2), mapped to indices 0-79; the 7-bit address counter (AC) SHALL point to one of these.
REQ-018 AC increment SHALL wrap 0x27->0x40 and 0x67->0x00; decrement SHALL wrap 0x40->0x27 and 0x00->0x67.
REQ-019 FSM states: IDLE, EXEC (busy countdown), CLEAR (fill); busy=1 in every state except IDLE.
REQ-020 Write strobe (rw=0) in IDLE: SHALL execute in that cycle, enter EXEC, load counter with BUSY_CYC; EXEC returns to IDLE when the counter reaches 0, so busy stays high exactly BUSY_CYC cycles.
REQ-021 Write strobe in EXEC or CLEAR: SHALL be discarded and SHALL set overrun.
REQ-022 Data write (rs=1): DDRAM[AC] <= data, then AC steps by the I/D bit (1 = increment).
REQ-023 Instructions SHALL decode by the highest set bit: 0x01 clear; 0x02-0x03 home (AC=0); 0000_01[I/D][S] entry mode (S stored, no shift effect); 0000_1[D][C][B] display control; 0001_[S/C][R/L]xx with S/C=0 moves AC by R/L (1 = increment), S/C=1 no effect; 001x_xxxx function set (stored, no effect); 01xx_xxxx CGRAM address (ignored); 1aaa_aaaa sets AC=aaaaaaa; an invalid address SHALL set AC=0x00.
REQ-024 Clear: SHALL enter CLEAR, write 0x20 to one DDRAM index per cycle (0..79), then set AC=0 and I/D=1, then enter EXEC for BUSY_CYC cycles; total busy = DDRAM_WORDS+BUSY_CYC cycles.
REQ-025 Read (rw=1): while lcd_en=1 and lcd_rw=1, lcd_data_oe=1 and lcd_data_out = {busy, AC} (rs=0) or DDRAM[AC] (rs=1); otherwise lcd_data_oe=0 and lcd_data_out=0x00.
REQ-026 Read strobe with rs=1 in IDLE SHALL step AC per I/D and SHALL NOT assert busy; reads in any state SHALL NOT set overrun.
REQ-027 A strobe coinciding with the final busy cycle SHALL be treated as arriving while busy.

Reset
REQ-028 On rst: AC=0, I/D=1, S=0, D=C=B=0, overrun=0, en_q=0, lcd_data_oe=0, lcd_data_out=0x00, counter=0, state=CLEAR at fill index 0 (busy=1).
REQ-029 Reset asserted mid-operation SHALL abort it and restart the power-on clear from index 0; DDRAM is not reset directly.

Configuration
REQ-030 Macro LCD_RESPONDER_BUSY_EN: defined -> busy timing per REQ-020/024. Undefined -> EXEC is skipped, busy is 1 only during CLEAR, and overrun is set only by writes during CLEAR.

Verification
REQ-031 Release rst -> busy=1 for 80+40 cycles; then dbg_data=0x20 at dbg_addr 0x00, 0x27, 0x40 and 0x67.
REQ-032 Write instr 0xA7 then data 0x41, 0x42 -> DDRAM[0x27]=0x41, DDRAM[0x40]=0x42, AC=0x41.
REQ-033 Instr 0x04 (I/D=0), instr 0x80, data 0x55 -> DDRAM[0x00]=0x55, AC=0x67.
REQ-034 Data 0x33 strobed 5 cycles after a prior write -> DDRAM unchanged, overrun=1 until rst.
REQ-035 Read with rs=0 right after a write -> lcd_data_out[7]=1, [6:0]=AC; after 40 cycles -> bit7=0.
REQ-036 Assert rst at fill index 30 of a clear -> fill restarts at 0; busy stays high 120 cycles after release.

Source files
------------

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style character LCD model seen from the CPU bus.
// Decodes write/read strobes on the falling edge of lcd_en, keeps an 80-byte
// two-line DDRAM with a wrapping address counter, and reports busy/overrun.
// Optional macro LCD_RESPONDER_BUSY_EN: when defined, every accepted write
// holds busy for BUSY_CYC cycles (EXEC state); when undefined, EXEC is skipped
// and busy is only raised by the DDRAM clear fill.
module lcd_responder #(
  parameter int BUSY_CYC    = 40,
  parameter int DDRAM_WORDS = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic       disp_on,
  output logic       overrun,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

`ifdef LCD_RESPONDER_BUSY_EN
  localparam bit BUSY_EN = (BUSY_CYC > 0);
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  localparam int IDX_W = $clog2(DDRAM_WORDS);
  localparam int CNT_W = $clog2(BUSY_CYC + 2);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   fill_idx;
  logic [6:0]         ac;
  logic               id;
  logic               en_q;
  logic [7:0]         ddram [DDRAM_WORDS];

  logic               strobe;
  logic               wr_strobe;
  logic               rd_strobe;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [7:0]         mem_wdata;

  // Step the address counter across the two-line gap in either direction.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h40)      return 7'h27;
      else if (a == 7'h00) return 7'h67;
      else                 return a - 7'd1;
    end
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Line 2 (0x40..0x67) follows line 1 (0x00..0x27) in the storage array.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [6:0] a);
    logic [6:0] i;
    i = a[6] ? (a - 7'd24) : a;
    return IDX_W'(i);
  endfunction

  assign strobe    = en_q & ~lcd_en;
  assign wr_strobe = strobe & ~lcd_rw;
  assign rd_strobe = strobe &  lcd_rw;
  assign busy      = (state != IDLE);

  // Select the single DDRAM write source for this cycle: clear fill or data write.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = 8'h00;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = fill_idx;
      mem_wdata = 8'h20;
    end else if (wr_strobe && lcd_rs && (state == IDLE)) begin
      mem_we    = 1'b1;
      mem_idx   = addr_idx(ac);
      mem_wdata = lcd_data_in;
    end
  end

  // DDRAM storage; contents survive reset and are rewritten by the clear fill.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset branch; resetting it would turn it
    // into a large bank of flops instead of a RAM.
    if (mem_we && !rst) ddram[mem_idx] <= mem_wdata;
  end

  // Control FSM: strobe decode, address counter, busy countdown and clear fill.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= CLEAR;
      fill_idx <= '0;
      cnt      <= '0;
      ac       <= 7'h00;
      id       <= 1'b1;
      disp_on  <= 1'b0;
      overrun  <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      en_q <= lcd_en;
      if (wr_strobe && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_strobe) begin
            if (BUSY_EN) begin
              state <= EXEC;
              cnt   <= CNT_W'(BUSY_CYC);
            end
            if (lcd_rs) begin
              ac <= ac_step(ac, id);
            end else begin
              // Instructions decode by their highest set bit; entry shift (S),
              // cursor/blink, shift-display and function set have no visible
              // effect in this model and are accepted without storage.
              casez (lcd_data_in)
                8'b1???_????: ac <= addr_valid(lcd_data_in[6:0]) ? lcd_data_in[6:0] : 7'h00;
                8'b01??_????: ;
                8'b001?_????: ;
                8'b0001_????: if (!lcd_data_in[3]) ac <= ac_step(ac, lcd_data_in[2]);
                8'b0000_1???: disp_on <= lcd_data_in[2];
                8'b0000_01??: id <= lcd_data_in[1];
                8'b0000_001?: ac <= 7'h00;
                8'b0000_0001: begin
                  state    <= CLEAR;
                  fill_idx <= '0;
                end
                default: ;
              endcase
            end
          end else if (rd_strobe && lcd_rs) begin
            ac <= ac_step(ac, id);
          end
        end

        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= IDLE;
        end

        CLEAR: begin
          if (fill_idx == IDX_W'(DDRAM_WORDS - 1)) begin
            fill_idx <= '0;
            ac       <= 7'h00;
            id       <= 1'b1;
            if (BUSY_EN) begin
              state <= EXEC;
              cnt   <= CNT_W'(BUSY_CYC);
            end else begin
              state <= IDLE;
            end
          end else begin
            fill_idx <= fill_idx + IDX_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Read-back bus: valid only while the CPU holds a read cycle open.
  always_comb begin
    lcd_data_oe  = 1'b0;
    lcd_data_out = 8'h00;
    if (!rst && lcd_en && lcd_rw) begin
      lcd_data_oe  = 1'b1;
      lcd_data_out = lcd_rs ? ddram[addr_idx(ac)] : {busy, ac};
    end
  end

  // Debug window into DDRAM; unmapped addresses read as zero.
  always_comb begin
    dbg_data = 8'h00;
    if (addr_valid(dbg_addr)) dbg_data = ddram[addr_idx(dbg_addr)];
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Testbench for lcd_responder: directed CPU bus sequence with an expected-value
// queue; expectations are pushed when stimulus is issued and popped at compare.
module tb_lcd_responder;

`ifdef LCD_RESPONDER_BUSY_EN
  localparam int BUSY_EFF = 40;
`else
  localparam int BUSY_EFF = 0;
`endif
  localparam int TOTAL = 80 + BUSY_EFF;
  localparam logic BUSY_BIT = (BUSY_EFF > 0);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_en = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic       busy;
  logic       disp_on;
  logic       overrun;
  logic [6:0] dbg_addr = 7'h00;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  lcd_responder dut (
    .clk          (clk),
    .rst          (rst),
    .lcd_en       (lcd_en),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .busy         (busy),
    .disp_on      (disp_on),
    .overrun      (overrun),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    checks++;
    if (val_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = val_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic cpu_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic rs, output logic [7:0] d, output logic oe);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    #1;
    d  = lcd_data_out;
    oe = lcd_data_oe;
    @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic dbg_check(input string tag, input logic [6:0] a, input logic [7:0] e);
    dbg_addr = a;
    expect_val(tag, {24'h0, e});
    #1;
    check_next({24'h0, dbg_data});
  endtask

  task automatic status_check(input string tag, input logic [7:0] e);
    logic [7:0] d;
    logic       oe;
    expect_val(tag, {23'h0, e, 1'b1});
    cpu_read(1'b0, d, oe);
    check_next({23'h0, d, oe});
  endtask

  task automatic cmd(input logic rs, input logic [7:0] d);
    int n;
    cpu_write(rs, d);
    wait_idle(n);
  endtask

  initial begin
    int         n;
    logic [7:0] d;
    logic       oe;

    // Power-on reset held: outputs at reset values.
    wait_cycles(3);
    expect_val("rst_busy", 32'd1);       check_next({31'h0, busy});
    expect_val("rst_oe", 32'd0);         check_next({31'h0, lcd_data_oe});
    expect_val("rst_out", 32'h00);       check_next({24'h0, lcd_data_out});
    expect_val("rst_overrun", 32'd0);    check_next({31'h0, overrun});
    expect_val("rst_disp_on", 32'd0);    check_next({31'h0, disp_on});

    // Release: power-on clear fill plus busy countdown.
    rst = 1'b0;
    expect_val("poweron_busy_cycles", TOTAL);
    wait_idle(n);
    check_next(n);
    dbg_check("clr_00", 7'h00, 8'h20);
    dbg_check("clr_27", 7'h27, 8'h20);
    dbg_check("clr_40", 7'h40, 8'h20);
    dbg_check("clr_67", 7'h67, 8'h20);
    dbg_check("dbg_unmapped", 7'h28, 8'h00);
    status_check("status_reset_ac", 8'h00);

    // Set AC to end of line 1, write two bytes across the line wrap.
    cmd(1'b0, 8'hA7);
    cmd(1'b1, 8'h41);
    cmd(1'b1, 8'h42);
    dbg_check("wr_27", 7'h27, 8'h41);
    dbg_check("wr_40", 7'h40, 8'h42);
    status_check("ac_after_wrap", 8'h41);

    // Decrement mode from address 0 wraps to 0x67.
    cmd(1'b0, 8'h04);
    cmd(1'b0, 8'h80);
    cmd(1'b1, 8'h55);
    dbg_check("dec_wr_00", 7'h00, 8'h55);
    status_check("dec_wrap_ac", 8'h67);

    // Busy bit visible in status right after a write, clear once idle.
    cpu_write(1'b0, 8'h80);
    status_check("status_busy_after_write", {BUSY_BIT, 7'h00});
    wait_idle(n);
    status_check("status_idle", 8'h00);

    // Write strobed shortly after a prior write (I/D=0, AC=0).
    cpu_write(1'b1, 8'h77);
    wait_cycles(2);
    cpu_write(1'b1, 8'h33);
    wait_idle(n);
    dbg_check("first_wr_00", 7'h00, 8'h77);
    dbg_check("late_wr_67", 7'h67, BUSY_BIT ? 8'h20 : 8'h33);
    expect_val("overrun_busy_write", {31'h0, BUSY_BIT});
    check_next({31'h0, overrun});
    status_check("ac_busy_write", BUSY_BIT ? 8'h67 : 8'h66);

    // Entry mode increment, display on, data read steps AC without busy.
    cmd(1'b0, 8'h06);
    cmd(1'b0, 8'h0C);
    expect_val("disp_on", 32'd1);
    check_next({31'h0, disp_on});
    cmd(1'b0, 8'hA7);
    expect_val("data_read", {23'h0, 8'h41, 1'b1});
    cpu_read(1'b1, d, oe);
    check_next({23'h0, d, oe});
    expect_val("read_no_busy", 32'd0);
    check_next({31'h0, busy});
    status_check("read_step_ac", 8'h40);

    // Cursor shift, display shift, function set, CGRAM, invalid address, home.
    cmd(1'b0, 8'h10);
    status_check("shift_left", 8'h27);
    cmd(1'b0, 8'h14);
    status_check("shift_right", 8'h40);
    cmd(1'b0, 8'h18);
    cmd(1'b0, 8'h3F);
    cmd(1'b0, 8'h55);
    status_check("no_effect_cmds", 8'h40);
    cmd(1'b0, 8'hA8);
    status_check("invalid_addr", 8'h00);
    cmd(1'b0, 8'hC5);
    status_check("set_addr_45", 8'h45);
    cmd(1'b0, 8'h03);
    status_check("home", 8'h00);

    // Increment wrap 0x67 -> 0x00.
    cmd(1'b0, 8'hE7);
    cmd(1'b1, 8'h5A);
    dbg_check("wr_67", 7'h67, 8'h5A);
    status_check("inc_wrap_ac", 8'h00);

    // Clear instruction: full busy length, fill, AC=0, I/D forced back to 1.
    cmd(1'b0, 8'h04);
    cpu_write(1'b0, 8'h01);
    expect_val("clear_busy_cycles", TOTAL);
    wait_idle(n);
    check_next(n);
    dbg_check("clear_27", 7'h27, 8'h20);
    dbg_check("clear_67", 7'h67, 8'h20);
    status_check("clear_ac", 8'h00);
    cmd(1'b1, 8'h11);
    status_check("clear_id_inc", 8'h01);

    // Reset in the middle of a clear fill restarts the full power-on clear.
    cpu_write(1'b0, 8'h01);
    wait_cycles(30);
    rst = 1'b1;
    wait_cycles(2);
    expect_val("midrst_overrun", 32'd0);  check_next({31'h0, overrun});
    expect_val("midrst_disp_on", 32'd0);  check_next({31'h0, disp_on});
    rst = 1'b0;
    expect_val("midrst_busy_cycles", TOTAL);
    wait_idle(n);
    check_next(n);
    dbg_check("midrst_00", 7'h00, 8'h20);

    // Strobe on the final busy cycle is discarded; the next one is accepted.
    cpu_write(1'b0, 8'h01);
    wait_cycles(TOTAL - 3);
    cpu_write(1'b1, 8'h99);
    wait_idle(n);
    dbg_check("final_cycle_discard", 7'h00, 8'h20);
    expect_val("final_cycle_overrun", 32'd1);
    check_next({31'h0, overrun});
    status_check("final_cycle_ac", 8'h00);
    cmd(1'b1, 8'h66);
    dbg_check("first_idle_accept", 7'h00, 8'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
